// File: rtl/go_sequencer.sv
// GO sequencer: start delay, then a fixed number of RDY_GO-qualified GO
// pulses separated by an idle gap; reports BUSY, DONE and the fired count.
module go_sequencer #(
  parameter int unsigned DELAY  = 4,
  parameter int unsigned PULSES = 1,
  parameter int unsigned GAP    = 2,
  parameter int unsigned CW     = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          RDY_GO,
  output logic          GO,
  output logic          BUSY,
  output logic          DONE,
  output logic [CW-1:0] COUNT
);

  if (PULSES >= (64'd1 << CW) || DELAY >= (64'd1 << CW) ||
      GAP >= (64'd1 << CW)) begin : g_bad_cfg
    $error("go_sequencer: PULSES/DELAY/GAP must fit in CW bits");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ARM,
    S_GAP,
    S_DONE
  } state_e;

  localparam logic [CW-1:0] DelayC  = CW'(DELAY);
  localparam logic [CW-1:0] PulsesC = CW'(PULSES);
  localparam logic [CW-1:0] GapC    = CW'(GAP);
  localparam logic [CW-1:0] OneC    = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic          fire;

  // Reset gates GO so no firing leaks out of a reset cycle.
  assign fire  = (state_q == S_ARM) && RDY_GO && !RST;
  assign GO    = fire;
  assign BUSY  = (state_q == S_WAIT) || (state_q == S_ARM) ||
                 (state_q == S_GAP);
  assign DONE  = (state_q == S_DONE);
  assign COUNT = count_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          count_d = '0;
          if (DELAY > 0) begin
            state_d = S_WAIT;
            cnt_d   = DelayC;
          end else if (PULSES > 0) begin
            state_d = S_ARM;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - OneC;
        if (cnt_q == OneC) state_d = S_ARM;
      end
      S_ARM: begin
        if (fire) begin
          count_d = count_q + OneC;
          if (count_q + OneC == PulsesC) begin
            state_d = S_DONE;
          end else if (GAP > 0) begin
            state_d = S_GAP;
            cnt_d   = GapC;
          end
        end
      end
      S_GAP: begin
        cnt_d = cnt_q - OneC;
        if (cnt_q == OneC) state_d = S_ARM;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_go_sequencer.sv
// Directed bench for go_sequencer: four parameter sets, expected
// cycle-by-cycle GO/BUSY/DONE/COUNT values worked out by hand.
module tb_go_sequencer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST0 = 1'b1, START0 = 1'b0, RDY0 = 1'b0;
  logic RST1 = 1'b1, START1 = 1'b0, RDY1 = 1'b0;
  logic RST2 = 1'b1, START2 = 1'b0, RDY2 = 1'b0;
  logic RST3 = 1'b1, START3 = 1'b0, RDY3 = 1'b0;
  logic GO0, BUSY0, DONE0;
  logic GO1, BUSY1, DONE1;
  logic GO2, BUSY2, DONE2;
  logic GO3, BUSY3, DONE3;
  logic [7:0] COUNT0, COUNT1, COUNT2, COUNT3;

  int checks = 0;
  int errors = 0;

  go_sequencer u0 (
    .CLK(CLK), .RST(RST0), .START(START0), .RDY_GO(RDY0),
    .GO(GO0), .BUSY(BUSY0), .DONE(DONE0), .COUNT(COUNT0)
  );

  go_sequencer #(.DELAY(0), .PULSES(3), .GAP(2)) u1 (
    .CLK(CLK), .RST(RST1), .START(START1), .RDY_GO(RDY1),
    .GO(GO1), .BUSY(BUSY1), .DONE(DONE1), .COUNT(COUNT1)
  );

  go_sequencer #(.DELAY(1), .PULSES(2), .GAP(0)) u2 (
    .CLK(CLK), .RST(RST2), .START(START2), .RDY_GO(RDY2),
    .GO(GO2), .BUSY(BUSY2), .DONE(DONE2), .COUNT(COUNT2)
  );

  go_sequencer #(.DELAY(0), .PULSES(0), .GAP(2)) u3 (
    .CLK(CLK), .RST(RST3), .START(START3), .RDY_GO(RDY3),
    .GO(GO3), .BUSY(BUSY3), .DONE(DONE3), .COUNT(COUNT3)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    tick();
    tick();
    RST0 = 1'b0; RST1 = 1'b0; RST2 = 1'b0; RST3 = 1'b0;
    chk("rst_busy0", BUSY0, 0);
    chk("rst_done0", DONE0, 0);
    chk("rst_count0", COUNT0, 0);
    chk("rst_go0", GO0, 0);

    // Defaults: GO only in cycle t0+5, DONE from t0+6
    RDY0 = 1'b1;
    START0 = 1'b1;
    tick();
    START0 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk($sformatf("d_go k%0d", k), GO0, (k == 5));
      chk($sformatf("d_busy k%0d", k), BUSY0, (k <= 5));
      chk($sformatf("d_done k%0d", k), DONE0, (k >= 6));
      tick();
    end
    chk("d_count", COUNT0, 1);

    // Restart from DONE, with START re-asserted during WAIT
    START0 = 1'b1;
    tick();
    START0 = 1'b0;
    chk("rs_count0", COUNT0, 0);
    for (int k = 1; k <= 7; k++) begin
      START0 = (k == 2);
      #1;
      chk($sformatf("rs_go k%0d", k), GO0, (k == 5));
      chk($sformatf("rs_done k%0d", k), DONE0, (k >= 6));
      tick();
    end
    START0 = 1'b0;
    chk("rs_count_end", COUNT0, 1);

    // Three pulses, gap 2: GO at t0+1, t0+4, t0+7
    RDY1 = 1'b1;
    START1 = 1'b1;
    tick();
    START1 = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      #1;
      chk($sformatf("p3_go k%0d", k), GO1,
          (k == 1 || k == 4 || k == 7));
      chk($sformatf("p3_cnt k%0d", k), COUNT1,
          (k >= 8) ? 3 : (k >= 5) ? 2 : (k >= 2) ? 1 : 0);
      chk($sformatf("p3_done k%0d", k), DONE1, (k >= 8));
      tick();
    end

    // Same run, START re-asserted during GAP
    START1 = 1'b1;
    tick();
    START1 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      START1 = (k == 3);
      #1;
      chk($sformatf("pg_go k%0d", k), GO1,
          (k == 1 || k == 4 || k == 7));
      tick();
    end
    START1 = 1'b0;
    chk("pg_count", COUNT1, 3);
    chk("pg_done", DONE1, 1);

    // Reset while in ARM with RDY_GO=1 and a partial count
    START1 = 1'b1;
    tick();
    START1 = 1'b0;
    tick();
    tick();
    tick();
    RST1 = 1'b1;
    #1;
    chk("ra_go", GO1, 0);
    chk("ra_partial", COUNT1, 1);
    tick();
    RST1 = 1'b0;
    chk("ra_count", COUNT1, 0);
    chk("ra_busy", BUSY1, 0);
    chk("ra_done", DONE1, 0);

    // Stall in ARM for 10 cycles, then back-to-back GO
    RDY2 = 1'b0;
    START2 = 1'b1;
    tick();
    START2 = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      RDY2 = (k == 1) || (k >= 12);
      #1;
      chk($sformatf("st_go k%0d", k), GO2, (k == 12 || k == 13));
      chk($sformatf("st_done k%0d", k), DONE2, (k >= 14));
      tick();
    end
    chk("st_count", COUNT2, 2);

    // Zero pulses: DONE one cycle after START, never GO
    RDY3 = 1'b1;
    START3 = 1'b1;
    tick();
    START3 = 1'b0;
    #1;
    chk("z_done", DONE3, 1);
    chk("z_busy", BUSY3, 0);
    chk("z_go", GO3, 0);
    chk("z_count", COUNT3, 0);

    // Reset wins over START
    RST3 = 1'b1;
    START3 = 1'b1;
    tick();
    RST3 = 1'b0;
    START3 = 1'b0;
    chk("rw_done", DONE3, 0);
    chk("rw_busy", BUSY3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
